rules9_seq: RTL and testbench



---
 rtl/rules9_seq.sv | 190 +++++++++++++++++++
 tb/tb_rules9_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rules9_seq.sv
// rtl/rules9_seq.sv - serial 3x3 fuzzy rule scheduler: min() weights, sum_w and sum_w*c accumulation
// Optional FUZZY_SEQ_WMAX_EN adds w_max / w_max_idx outputs (strongest rule, lowest index on ties).
module rules9_seq #(
    parameter int MU_W  = 16,
    parameter int C_W   = 16,
    parameter int SW_W  = 20,
    parameter int SWC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MU_W-1:0]         muT_neg,
    input  logic [MU_W-1:0]         muT_zero,
    input  logic [MU_W-1:0]         muT_pos,
    input  logic [MU_W-1:0]         muD_neg,
    input  logic [MU_W-1:0]         muD_zero,
    input  logic [MU_W-1:0]         muD_pos,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic signed [C_W-1:0]   cfg_data,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SW_W-1:0]         sum_w,
    output logic signed [SWC_W-1:0] sum_wc
`ifdef FUZZY_SEQ_WMAX_EN
    ,
    output logic [MU_W-1:0]         w_max,
    output logic [3:0]              w_max_idx
`endif
);

    localparam int P_W = MU_W + C_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [MU_W-1:0]         r_mu_t [0:2];
    logic [MU_W-1:0]         r_mu_d [0:2];
    logic signed [C_W-1:0]   r_cons [0:8];
    logic [3:0]              r_idx;
    logic                    r_pv;
    logic [MU_W-1:0]         r_pw;
    logic signed [P_W-1:0]   r_pprod;
    logic [SW_W-1:0]         r_sum_w;
    logic signed [SWC_W-1:0] r_sum_wc;
`ifdef FUZZY_SEQ_WMAX_EN
    logic [3:0]              r_pidx;
    logic [MU_W-1:0]         r_wmax;
    logic [3:0]              r_wmax_idx;
`endif

    logic                    w_accept;
    logic                    w_cfg_wr;
    logic [3:0]              w_td;
    logic [3:0]              w_cidx;
    logic [MU_W-1:0]         w_a;
    logic [MU_W-1:0]         w_b;
    logic [MU_W-1:0]         w_w;
    logic signed [C_W-1:0]   w_c;
    logic signed [P_W-1:0]   w_wx;
    logic signed [P_W-1:0]   w_cx;
    logic signed [P_W-1:0]   w_prod;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_cfg_wr = cfg_we && (r_state == S_IDLE) && (cfg_addr < 4'd9);

    // Rule k = 3*i + j: upper two bits select the T set, lower two the dT set.
    always_comb begin
        w_td = 4'b0000;
        case (r_idx)
            4'd0:    w_td = 4'b0000;
            4'd1:    w_td = 4'b0001;
            4'd2:    w_td = 4'b0010;
            4'd3:    w_td = 4'b0100;
            4'd4:    w_td = 4'b0101;
            4'd5:    w_td = 4'b0110;
            4'd6:    w_td = 4'b1000;
            4'd7:    w_td = 4'b1001;
            4'd8:    w_td = 4'b1010;
            default: w_td = 4'b0000;
        endcase
    end

    assign w_cidx = (r_idx < 4'd9) ? r_idx : 4'd0;
    assign w_a    = r_mu_t[w_td[3:2]];
    assign w_b    = r_mu_d[w_td[1:0]];
    assign w_w    = (w_a < w_b) ? w_a : w_b;
    assign w_c    = r_cons[w_cidx];
    assign w_wx   = $signed({{C_W{1'b0}}, 1'b0, w_w});
    assign w_cx   = {{(MU_W+1){w_c[C_W-1]}}, w_c};
    assign w_prod = w_wx * w_cx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (r_idx == 4'd9) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Two-stage datapath: min/multiply registered, then accumulated one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_mu_t[k] <= '0;
                r_mu_d[k] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                r_cons[k] <= '0;
            end
            r_idx    <= '0;
            r_pv     <= 1'b0;
            r_pw     <= '0;
            r_pprod  <= '0;
            r_sum_w  <= '0;
            r_sum_wc <= '0;
`ifdef FUZZY_SEQ_WMAX_EN
            r_pidx     <= '0;
            r_wmax     <= '0;
            r_wmax_idx <= '0;
`endif
        end else begin
            if (w_cfg_wr) begin
                r_cons[cfg_addr] <= cfg_data;
            end
            if (w_accept) begin
                r_mu_t[0] <= muT_neg;
                r_mu_t[1] <= muT_zero;
                r_mu_t[2] <= muT_pos;
                r_mu_d[0] <= muD_neg;
                r_mu_d[1] <= muD_zero;
                r_mu_d[2] <= muD_pos;
                r_idx     <= '0;
                r_pv      <= 1'b0;
                r_sum_w   <= '0;
                r_sum_wc  <= '0;
`ifdef FUZZY_SEQ_WMAX_EN
                r_wmax     <= '0;
                r_wmax_idx <= '0;
`endif
            end else if (r_state == S_RUN) begin
                if (r_idx < 4'd9) begin
                    r_pv    <= 1'b1;
                    r_pw    <= w_w;
                    r_pprod <= w_prod;
                    r_idx   <= r_idx + 4'd1;
`ifdef FUZZY_SEQ_WMAX_EN
                    r_pidx  <= r_idx;
`endif
                end else begin
                    r_pv <= 1'b0;
                end
                if (r_pv) begin
                    r_sum_w  <= r_sum_w + {{(SW_W-MU_W){1'b0}}, r_pw};
                    r_sum_wc <= r_sum_wc + {{(SWC_W-P_W){r_pprod[P_W-1]}}, r_pprod};
`ifdef FUZZY_SEQ_WMAX_EN
                    if (r_pw > r_wmax) begin
                        r_wmax     <= r_pw;
                        r_wmax_idx <= r_pidx;
                    end
`endif
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum_w     = r_sum_w;
    assign sum_wc    = r_sum_wc;
`ifdef FUZZY_SEQ_WMAX_EN
    assign w_max     = r_wmax;
    assign w_max_idx = r_wmax_idx;
`endif

endmodule

// File: tb/tb_rules9_seq.sv
// tb/tb_rules9_seq.sv - directed self-checking bench for rules9_seq
module tb_rules9_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        muT_neg, muT_zero, muT_pos;
    logic [15:0]        muD_neg, muD_zero, muD_pos;
    logic               cfg_we;
    logic [3:0]         cfg_addr;
    logic signed [15:0] cfg_data;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [19:0]        sum_w;
    logic signed [39:0] sum_wc;
`ifdef FUZZY_SEQ_WMAX_EN
    logic [15:0]        w_max;
    logic [3:0]         w_max_idx;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] bt [0:2][0:2];
    logic [15:0] bd [0:2][0:2];
    longint      bc [0:8];

    rules9_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .muT_neg   (muT_neg),
        .muT_zero  (muT_zero),
        .muT_pos   (muT_pos),
        .muD_neg   (muD_neg),
        .muD_zero  (muD_zero),
        .muD_pos   (muD_pos),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_w     (sum_w),
        .sum_wc    (sum_wc)
`ifdef FUZZY_SEQ_WMAX_EN
        ,
        .w_max     (w_max),
        .w_max_idx (w_max_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic signed [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic set_mu(input logic [15:0] t0, t1, t2, d0, d1, d2);
        muT_neg  = t0; muT_zero = t1; muT_pos = t2;
        muD_neg  = d0; muD_zero = d1; muD_pos = d2;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd10);
    endtask

    task automatic do_run(input string tag, input logic [15:0] t0, t1, t2, d0, d1, d2,
                          input longint ew, input longint ewc,
                          input logic [15:0] ewm, input logic [3:0] ewi);
        int n;
        set_mu(t0, t1, t2, d0, d1, d2);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(tag, n);
        check({tag, " sum_w"}, 64'(sum_w), ew);
        check({tag, " sum_wc"}, $signed(sum_wc), ewc);
`ifdef FUZZY_SEQ_WMAX_EN
        check({tag, " w_max"}, 64'(w_max), 64'(ewm));
        check({tag, " w_max_idx"}, 64'(w_max_idx), 64'(ewi));
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic model(input int r, output longint ew, output longint ewc,
                         output logic [15:0] wm, output logic [3:0] wi);
        longint w;
        ew = 0; ewc = 0; wm = 16'd0; wi = 4'd0;
        for (int k = 0; k < 9; k++) begin
            w = (bt[r][k/3] < bd[r][k%3]) ? longint'(bt[r][k/3]) : longint'(bd[r][k%3]);
            ew  += w;
            ewc += w * bc[k];
            if (w > longint'(wm)) begin
                wm = 16'(w);
                wi = 4'(k);
            end
        end
    endtask

    initial begin
        int n;
        int bad;
        longint ew, ewc;
        logic [15:0] wm;
        logic [3:0] wi;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 16'sd0;
        set_mu(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        #12;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst sum_w", 64'(sum_w), 64'd0);
        check("rst sum_wc", $signed(sum_wc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic run with c[k] = k
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 16'(k));
        do_run("basic", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 319488, 16'h8000, 4'd4);
        release_out("basic");

        // Extremes: full-scale weights, most negative consequent
        for (int k = 0; k < 9; k++) cfg_write(4'(k), -16'sd32768);
        do_run("extreme", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
               589815, -64'sd19327057920, 16'hFFFF, 4'd0);
        release_out("extreme");

        // Backpressure: hold result 20 cycles while a new set is offered
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 16'(k));
        do_run("bp", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 319488, 16'h8000, 4'd4);
        set_mu(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sum_w !== 20'd65536 || sum_wc !== 40'sd319488 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        check("bp hold stable", 64'(bad), 64'd0);
        in_valid = 1'b0;
        release_out("bp");
        tick();
        check("bp no new run", 64'(busy), 64'd0);

        // Config write during RUN is dropped
        set_mu(16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cfg_write(4'd4, 16'sd100);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("cfg busy out_valid", 64'(out_valid), 64'd1);
        check("cfg busy sum_wc", $signed(sum_wc), 64'd319488);
        release_out("cfg busy");
        cfg_write(4'd4, 16'sd100);
        do_run("cfg idle", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 3465216, 16'h8000, 4'd4);
        release_out("cfg idle");
        cfg_write(4'd12, 16'sd7);
        do_run("cfg addr12", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 3465216, 16'h8000, 4'd4);
        release_out("cfg addr12");

        // Reset at RUN cycle 5
        set_mu(16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst sum_w", 64'(sum_w), 64'd0);
        check("midrst sum_wc", $signed(sum_wc), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_run("post rst cons0", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 0, 16'h8000, 4'd4);
        release_out("post rst cons0");
        for (int k = 0; k < 9; k++) cfg_write(4'(k), 16'(k));
        do_run("post rst", 16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'hFFFF, 16'h0000,
               65536, 319488, 16'h8000, 4'd4);
        release_out("post rst");

        // Back-to-back with in_valid and out_ready held high
        for (int k = 0; k < 9; k++) begin
            bc[k] = longint'(1000 * k - 4000);
            cfg_write(4'(k), 16'(1000 * k - 4000));
        end
        bt[0][0] = 16'h0000; bt[0][1] = 16'h8000; bt[0][2] = 16'h4000;
        bd[0][0] = 16'h2000; bd[0][1] = 16'hFFFF; bd[0][2] = 16'h0000;
        bt[1][0] = 16'h1234; bt[1][1] = 16'hFFFF; bt[1][2] = 16'h0100;
        bd[1][0] = 16'hFFFF; bd[1][1] = 16'h0800; bd[1][2] = 16'h7000;
        bt[2][0] = 16'hABCD; bt[2][1] = 16'h0000; bt[2][2] = 16'h5555;
        bd[2][0] = 16'h5555; bd[2][1] = 16'hFFFE; bd[2][2] = 16'h0001;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_mu(bt[r][0], bt[r][1], bt[r][2], bd[r][0], bd[r][1], bd[r][2]);
            n = 0;
            while (!in_ready && n < 20) begin tick(); n++; end
            check("b2b ready", 64'(in_ready), 64'd1);
            tick();
            set_mu(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            model(r, ew, ewc, wm, wi);
            wait_out("b2b", n);
            check("b2b sum_w", 64'(sum_w), ew);
            check("b2b sum_wc", $signed(sum_wc), ewc);
`ifdef FUZZY_SEQ_WMAX_EN
            check("b2b w_max", 64'(w_max), 64'(wm));
            check("b2b w_max_idx", 64'(w_max_idx), 64'(wi));
`endif
        end
        in_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
